// File: rtl/mem_bus_router_pkg.sv
// Shared bus types, router state encoding and the SoC slave address map.
package mem_bus_router_pkg;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [3:0]  mem_wstrb;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic        mem_error;
        logic [31:0] mem_rdata;
    } mem_out_type;

    localparam mem_in_type  init_mem_in  = '0;
    localparam mem_out_type init_mem_out = '0;

    typedef enum logic [2:0] {IDLE, BUSY, DRAIN, REPLAY} router_state_t;

    localparam int NSLV_SOC = 4;
    localparam logic [31:0] slave_base_addr [NSLV_SOC] =
        '{32'h0000_0000, 32'h0000_1000, 32'h0000_2000, 32'h8000_0000};
    localparam logic [31:0] slave_mask_addr [NSLV_SOC] = '{default: 32'h0000_0FFF};

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_router_if.sv
// Bundle of master-side and slave-side bus signals around the router.
interface mem_bus_router_if
    import mem_bus_router_pkg::*;
#(
    parameter int NSLV = 8
);
    mem_in_type               mem_in;
    mem_out_type              mem_out;
    mem_in_type  [NSLV-1:0]   slv_in;
    mem_out_type [NSLV-1:0]   slv_out;
    logic                     busy;
    logic                     err_decode;
    logic                     err_tout;

    // master: the side issuing requests and modelling peripherals
    modport master (
        output mem_in, slv_out,
        input  mem_out, slv_in, busy, err_decode, err_tout
    );

    // slave: the router itself
    modport slave (
        input  mem_in, slv_out,
        output mem_out, slv_in, busy, err_decode, err_tout
    );
endinterface

// File: rtl/mem_bus_router_decode.sv
// Combinational base/mask address decoder; lowest matching slave index wins.
module mem_bus_decode
    import mem_bus_router_pkg::*;
#(
    parameter int          NSLV = 8,
    parameter logic [31:0] BASE_ADDR [NSLV] = '{default: 32'h0},
    parameter logic [31:0] MASK_ADDR [NSLV] = '{default: 32'h0},
    localparam int         IW = idx_width(NSLV)
) (
    input  logic [31:0]   i_addr,
    output logic          o_hit,
    output logic [IW-1:0] o_index,
    output logic [31:0]   o_offset
);

    // Scan downwards so the lowest matching index is the last one written.
    always_comb begin
        o_hit    = 1'b0;
        o_index  = '0;
        o_offset = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (~|(BASE_ADDR[i] ^ (i_addr & ~MASK_ADDR[i]))) begin
                o_hit    = 1'b1;
                o_index  = IW'(i);
                o_offset = i_addr - BASE_ADDR[i];
            end
        end
    end

endmodule

// File: rtl/mem_bus_router.sv
// N-slave memory bus router: address decode, response return, decode/timeout
// error generation, and draining of late replies with a one-entry request buffer.
module mem_bus_router
    import mem_bus_router_pkg::*;
#(
    parameter int          NSLV      = 8,
    parameter logic [31:0] BASE_ADDR [NSLV] = '{default: 32'h0},
    parameter logic [31:0] MASK_ADDR [NSLV] = '{default: 32'h0},
    parameter int          TIMEOUT   = 1023
) (
    input  logic           clock,
    input  logic           reset,
    mem_bus_router_if.slave bus
);

    localparam int IW = idx_width(NSLV);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam bit TOUT_EN = (TIMEOUT > 0);

    router_state_t          r_state;
    logic [IW-1:0]          r_sel;
    logic [CW-1:0]          r_cnt;
    mem_in_type             r_buf;
    logic                   r_buf_full;
    mem_out_type            r_mem_out;
    logic                   r_err_decode;
    logic                   r_err_tout;

    logic                   w_live_hit;
    logic [IW-1:0]          w_live_idx;
    logic [31:0]            w_live_off;
    logic                   w_buf_hit;
    logic [IW-1:0]          w_buf_idx;
    logic [31:0]            w_buf_off;
    logic                   w_sel_ready;
    logic                   w_cnt_limit;
    mem_in_type [NSLV-1:0]  w_slv_in;

    mem_bus_decode #(.NSLV(NSLV), .BASE_ADDR(BASE_ADDR), .MASK_ADDR(MASK_ADDR)) u_dec_live (
        .i_addr   (bus.mem_in.mem_addr),
        .o_hit    (w_live_hit),
        .o_index  (w_live_idx),
        .o_offset (w_live_off)
    );

    mem_bus_decode #(.NSLV(NSLV), .BASE_ADDR(BASE_ADDR), .MASK_ADDR(MASK_ADDR)) u_dec_buf (
        .i_addr   (r_buf.mem_addr),
        .o_hit    (w_buf_hit),
        .o_index  (w_buf_idx),
        .o_offset (w_buf_off)
    );

    assign w_sel_ready = bus.slv_out[r_sel].mem_ready;
    assign w_cnt_limit = TOUT_EN && (r_cnt == LIMIT);

    // Requests reach the slave in the cycle they are issued (live) or replayed.
    always_comb begin
        for (int s = 0; s < NSLV; s++) begin
            w_slv_in[s] = init_mem_in;
        end
        if (r_state == IDLE && bus.mem_in.mem_valid && w_live_hit) begin
            w_slv_in[w_live_idx]          = bus.mem_in;
            w_slv_in[w_live_idx].mem_addr = w_live_off;
        end else if (r_state == REPLAY && w_buf_hit) begin
            w_slv_in[w_buf_idx]           = r_buf;
            w_slv_in[w_buf_idx].mem_valid = 1'b1;
            w_slv_in[w_buf_idx].mem_addr  = w_buf_off;
        end
    end

    assign bus.slv_in     = w_slv_in;
    assign bus.mem_out    = (r_state == BUSY && w_sel_ready) ? bus.slv_out[r_sel] : r_mem_out;
    assign bus.busy       = (r_state != IDLE);
    assign bus.err_decode = r_err_decode;
    assign bus.err_tout   = r_err_tout;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_sel        <= '0;
            r_cnt        <= '0;
            r_buf        <= init_mem_in;
            r_buf_full   <= 1'b0;
            r_mem_out    <= init_mem_out;
            r_err_decode <= 1'b0;
            r_err_tout   <= 1'b0;
        end else begin
            r_mem_out    <= init_mem_out;
            r_err_decode <= 1'b0;
            r_err_tout   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.mem_in.mem_valid) begin
                        if (w_live_hit) begin
                            r_sel   <= w_live_idx;
                            r_cnt   <= '0;
                            r_state <= BUSY;
                        end else begin
                            r_mem_out    <= '{mem_ready: 1'b1, mem_error: 1'b1, mem_rdata: 32'h0};
                            r_err_decode <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (w_sel_ready) begin
                        r_state <= IDLE;
                    end else if (w_cnt_limit) begin
                        r_mem_out  <= '{mem_ready: 1'b1, mem_error: 1'b1, mem_rdata: 32'h0};
                        r_err_tout <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= DRAIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    // A request arriving on the exit cycle is still captured and replayed.
                    if (bus.mem_in.mem_valid && !r_buf_full) begin
                        r_buf      <= bus.mem_in;
                        r_buf_full <= 1'b1;
                    end
                    if (w_sel_ready || w_cnt_limit) begin
                        r_state <= (r_buf_full || bus.mem_in.mem_valid) ? REPLAY : IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                REPLAY: begin
                    r_buf_full <= 1'b0;
                    if (w_buf_hit) begin
                        r_sel   <= w_buf_idx;
                        r_cnt   <= '0;
                        r_state <= BUSY;
                    end else begin
                        r_mem_out    <= '{mem_ready: 1'b1, mem_error: 1'b1, mem_rdata: 32'h0};
                        r_err_decode <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_router.sv
// Directed scoreboard bench for mem_bus_router on the 4-slave SoC map, TIMEOUT=8.
module tb_mem_bus_router;
    import mem_bus_router_pkg::*;

    localparam int TOUT = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;

    typedef struct {
        int          idx;
        logic [31:0] addr;
        int          at;
    } sreq_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic        dec;
        logic        tout;
        int          at;
    } rsp_t;

    sreq_t sreq_q[$];
    rsp_t  rsp_q[$];

    mem_bus_router_if #(.NSLV(NSLV_SOC)) bus ();

    mem_bus_router #(
        .NSLV      (NSLV_SOC),
        .BASE_ADDR (slave_base_addr),
        .MASK_ADDR (slave_mask_addr),
        .TIMEOUT   (TOUT)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] got);
        checks++;
        failures++;
        $display("FAIL %s: got %0h expected nothing (cycle %0d)", name, got, cyc);
    endtask

    // Advance one cycle and drop all single-cycle pulses driven by the bench.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.mem_in.mem_valid = 1'b0;
        for (int s = 0; s < NSLV_SOC; s++) bus.slv_out[s] = init_mem_out;
    endtask

    task automatic req(input logic [31:0] addr);
        bus.mem_in = '{mem_valid: 1'b1, mem_instr: 1'b0, mem_wstrb: 4'h0,
                       mem_addr: addr, mem_wdata: 32'h0};
    endtask

    task automatic sready(input int idx, input logic err, input logic [31:0] rdata);
        bus.slv_out[idx] = '{mem_ready: 1'b1, mem_error: err, mem_rdata: rdata};
    endtask

    task automatic exp_sreq(input int idx, input logic [31:0] addr, input int at);
        sreq_q.push_back('{idx: idx, addr: addr, at: at});
    endtask

    task automatic exp_rsp(input logic err, input logic [31:0] rdata, input logic dec,
                           input logic tout, input int at);
        rsp_q.push_back('{err: err, rdata: rdata, dec: dec, tout: tout, at: at});
    endtask

    // Monitor: compares every slave request and master response against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int s = 0; s < NSLV_SOC; s++) begin
                if (bus.slv_in[s].mem_valid) begin
                    if (sreq_q.size() == 0) begin
                        unexpected("slv_req", {32'(s), bus.slv_in[s].mem_addr});
                    end else begin
                        sreq_t e;
                        e = sreq_q.pop_front();
                        chk("slv_req_idx", 64'(s), 64'(e.idx));
                        chk("slv_req_addr", 64'(bus.slv_in[s].mem_addr), 64'(e.addr));
                        chk("slv_req_cycle", 64'(cyc), 64'(e.at));
                    end
                end
            end
            if (bus.mem_out.mem_ready) begin
                if (rsp_q.size() == 0) begin
                    unexpected("rsp", 64'(bus.mem_out));
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    chk("rsp_error", 64'(bus.mem_out.mem_error), 64'(r.err));
                    chk("rsp_rdata", 64'(bus.mem_out.mem_rdata), 64'(r.rdata));
                    chk("rsp_err_decode", 64'(bus.err_decode), 64'(r.dec));
                    chk("rsp_err_tout", 64'(bus.err_tout), 64'(r.tout));
                    chk("rsp_cycle", 64'(cyc), 64'(r.at));
                end
            end else if (bus.err_decode || bus.err_tout) begin
                unexpected("stray_err_pulse", {62'h0, bus.err_decode, bus.err_tout});
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_mem_out"}, 64'(bus.mem_out), 64'(init_mem_out));
        for (int s = 0; s < NSLV_SOC; s++) chk({tag, "_slv_in"}, 64'(bus.slv_in[s].mem_valid), 64'h0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'h0);
        chk({tag, "_err"}, {62'h0, bus.err_decode, bus.err_tout}, 64'h0);
    endtask

    initial begin
        int t;
        bus.mem_in = init_mem_in;
        for (int s = 0; s < NSLV_SOC; s++) bus.slv_out[s] = init_mem_out;

        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Read from slave 1, reply three cycles later.
        tick();
        t = cyc;
        req(32'h0000_1004);
        exp_sreq(1, 32'h4, t);
        exp_rsp(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, t + 3);
        tick();
        @(negedge clk);
        chk("busy_in_busy", 64'(bus.busy), 64'h1);
        tick();
        tick();
        sready(1, 1'b0, 32'hDEAD_BEEF);

        // Back-to-back unmapped access.
        tick();
        t = cyc;
        req(32'h0000_4000);
        exp_rsp(1'b1, 32'h0, 1'b1, 1'b0, t + 1);
        tick();
        tick();

        // Silent slave 2: timeout, drain with buffered and dropped requests, then replay.
        tick();
        t = cyc;
        req(32'h0000_2000);
        exp_sreq(2, 32'h0, t);
        exp_rsp(1'b1, 32'h0, 1'b0, 1'b1, t + TOUT + 1);
        repeat (TOUT + 2) tick();
        req(32'h0000_0010);
        tick();
        req(32'h0000_1008);
        @(negedge clk);
        chk("busy_in_drain", 64'(bus.busy), 64'h1);
        tick();
        sready(2, 1'b0, 32'h0BAD_0BAD);
        exp_sreq(0, 32'h10, t + 13);
        tick();
        tick();
        tick();
        sready(0, 1'b1, 32'h1234_5678);
        exp_rsp(1'b1, 32'h1234_5678, 1'b0, 1'b0, t + 15);
        tick();
        tick();

        // Slave 3 answers on the limit cycle; stray ready and a protocol-violating request are ignored.
        tick();
        t = cyc;
        req(32'h8000_0020);
        exp_sreq(3, 32'h20, t);
        exp_rsp(1'b0, 32'h55, 1'b0, 1'b0, t + TOUT);
        tick();
        tick();
        sready(1, 1'b0, 32'h0000_0BAD);
        tick();
        req(32'h0000_1000);
        repeat (TOUT - 3) tick();
        sready(3, 1'b0, 32'h55);
        tick();
        tick();

        // Reset while busy aborts silently; the next request proceeds normally.
        tick();
        t = cyc;
        req(32'h0000_1000);
        exp_sreq(1, 32'h0, t);
        tick();
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("midreset");
        tick();
        rst_n = 1'b1;
        tick();
        t = cyc;
        req(32'h0000_1010);
        exp_sreq(1, 32'h10, t);
        exp_rsp(1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, t + 1);
        tick();
        sready(1, 1'b0, 32'hCAFE_F00D);
        tick();
        repeat (3) tick();

        chk("pending_slv_reqs", 64'(sreq_q.size()), 64'h0);
        chk("pending_rsps", 64'(rsp_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
